// File: rtl/bb_gen_pkg.sv
// bb_gen_pkg: action/result/state enums, result codes and a 4-bit popcount shared by the scorer
package bb_gen_pkg;
  typedef enum logic [2:0] {
    ACT_WALK, ACT_SINGLE, ACT_DOUBLE, ACT_TRIPLE, ACT_HR, ACT_BUNT, ACT_GROUND, ACT_FLY
  } action_t;
  typedef enum logic [1:0] {RESULT_A = 2'b00, RESULT_B = 2'b01, RESULT_TIE = 2'b10} result_t;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;
  localparam logic [1:0] RES_A = 2'b00;
  localparam logic [1:0] RES_B = 2'b01;
  localparam logic [1:0] RES_TIE = 2'b10;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/bb_play_step.sv
// bb_play_step: applies one action to (bases, outs), giving next bases, next outs (0..3) and runs (0..4)
module bb_play_step
  import bb_gen_pkg::*;
(
  input  logic [2:0] bases,
  input  logic [1:0] outs,
  input  logic [2:0] action,
  output logic [2:0] next_bases,
  output logic [1:0] next_outs,
  output logic [2:0] runs
);
  action_t act;
  logic two_out, out_done;
  logic [1:0] k, outs_add;
  logic [2:0] adv_src, batter, walk_bases, raw_bases, raw_runs, total;
  logic [6:0] moved;
  always_comb begin
    act = action_t'(action);
    two_out = outs == 2'd2;
    k = act == ACT_SINGLE ? (two_out ? 2'd2 : 2'd1) :
        act == ACT_DOUBLE ? (two_out ? 2'd3 : 2'd2) :
        (act == ACT_TRIPLE || act == ACT_HR) ? 2'd3 :
        (act == ACT_BUNT || act == ACT_GROUND) ? 2'd1 : 2'd0;
    // on a ground ball the runner on 1st is part of the double play, so he never advances
    adv_src = act == ACT_GROUND ? (bases & 3'b110) : bases;
    // bits shifted past bit 2 are runners who crossed home
    moved = {4'b0, adv_src} << k;
    batter = act == ACT_SINGLE ? 3'b001 : act == ACT_DOUBLE ? 3'b010 : act == ACT_TRIPLE ? 3'b100 : 3'b000;
    walk_bases = {bases[2] | (bases[1] & bases[0]), bases[1] | bases[0], 1'b1};
    raw_bases = act == ACT_WALK ? walk_bases : act == ACT_FLY ? {1'b0, bases[1:0]} : (moved[2:0] | batter);
    raw_runs = act == ACT_WALK ? {2'b0, &bases} :
               act == ACT_FLY ? {2'b0, bases[2]} :
               popcount4(moved[6:3]) + {2'b0, act == ACT_HR};
    outs_add = act == ACT_GROUND ? (bases[0] ? 2'd2 : 2'd1) :
               (act == ACT_BUNT || act == ACT_FLY) ? 2'd1 : 2'd0;
    total = {1'b0, outs} + {1'b0, outs_add};
    out_done = total >= 3'd3;
    next_outs = out_done ? 2'd3 : total[1:0];
    next_bases = out_done ? 3'b000 : raw_bases;
    runs = out_done ? 3'd0 : raw_runs;
  end
endmodule

// File: rtl/bb_scorer_gen.sv
// bb_scorer_gen: scores a game stream (in_valid/inning/half/action) and strobes final score_A/score_B/result on out_valid
module bb_scorer_gen
  import bb_gen_pkg::*;
#(
  parameter int INNING_W = 4,
  parameter int N_INNINGS = 9,
  parameter int SCORE_W = 8,
  parameter int EXTRA_EN = 1,
  parameter int GHOST_EN = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [INNING_W-1:0] inning,
  input  logic                half,
  input  logic [2:0]          action,
  output logic                out_valid,
  output logic [SCORE_W-1:0]  score_A,
  output logic [SCORE_W-1:0]  score_B,
  output logic [1:0]          result
);
  localparam logic [INNING_W-1:0] N_REG = INNING_W'(N_INNINGS);
  state_t state, state_nx;
  result_t res;
  logic [SCORE_W-1:0] sa, sb, sa_nx, sb_nx;
  logic [2:0] bases, b_in, step_bases, runs;
  logic [1:0] outs, o_in, step_outs;
  logic [INNING_W-1:0] prev_inn;
  logic prev_half, boundary, extra, live, accept, walk_off;
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [2:0] r);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(r);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction
  bb_play_step u_step (
    .bases(b_in),
    .outs(o_in),
    .action(action),
    .next_bases(step_bases),
    .next_outs(step_outs),
    .runs(runs)
  );
  always_comb begin
    extra = inning > N_REG;
    // prev_inn is cleared to 0 (never a legal inning), so a game's first beat is always a boundary
    boundary = inning != prev_inn || half != prev_half;
    b_in = boundary ? ((GHOST_EN != 0 && extra) ? 3'b010 : 3'b000) : bases;
    o_in = boundary ? 2'd0 : outs;
    live = in_valid && state != S_DONE && (EXTRA_EN != 0 || !extra);
    accept = live && o_in != 2'd3;
    sa_nx = (accept && !half) ? sat_add(sa, runs) : sa;
    sb_nx = (accept && half) ? sat_add(sb, runs) : sb;
    // a walk-off ends the half by forcing three outs
    walk_off = accept && half && inning >= N_REG && sb_nx > sa_nx;
  end
  always_ff @(posedge clk) begin
    if (rst || state == S_DONE) begin
      sa <= '0;
      sb <= '0;
      bases <= '0;
      outs <= '0;
      prev_inn <= '0;
      prev_half <= 1'b0;
    end else if (live) begin
      prev_inn <= inning;
      prev_half <= half;
      bases <= accept ? step_bases : b_in;
      outs <= walk_off ? 2'd3 : accept ? step_outs : o_in;
      sa <= sa_nx;
      sb <= sb_nx;
    end
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_comb
    state_nx = state == S_IDLE ? (in_valid ? S_PLAY : S_IDLE) :
               state == S_PLAY ? (in_valid ? S_PLAY : S_DONE) : S_IDLE;
  always_comb begin
    out_valid = state == S_DONE;
    score_A = out_valid ? sa : '0;
    score_B = out_valid ? sb : '0;
    res = !out_valid ? RESULT_A : sb > sa ? RESULT_B : sa > sb ? RESULT_A : RESULT_TIE;
    result = res;
  end
endmodule
